// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single SDRAM command channel between the ROM loader write
//   port (port 0) and the CPU/GFX/sound read ports.  Only one command is
//   ever in flight.  While rom_load is high, only port 0 may be granted.
//   Otherwise the ports are served round-robin, starting from rr_ptr.
//
// Handshake (requester side): a port has a transfer pending while
//   port_req[i] != port_ack[i].  The requester toggles port_req[i] to issue
//   a transfer.  It holds port_we/addr/din/be stable until port_ack[i]
//   toggles to match.  On a read, port_dout is valid in the cycle the ack
//   toggles.
// Handshake (controller side): sdr_req is a one-cycle command strobe, and
//   the sdr_* command fields stay stable until completion.  sdr_rdy is a
//   one-cycle completion pulse, and sdr_dout is valid while sdr_rdy is high.
//
// Ports
//   ram_clk, reset            clock (rising edge), synchronous active-high reset
//   rom_load                  download active: port 0 only
//   port_req / port_ack       per-port toggle request / acknowledge
//   port_we/addr/din/be       packed per-port command fields, port i at [i*W +: W]
//   port_dout                 read data of the last completed read
//   sdr_req/we/addr/din/be    command to the SDRAM controller
//   sdr_rdy / sdr_dout        completion pulse and read data from the controller
//   busy                      high from grant until completion (equals state == S_WAIT)

module sdram_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int AW        = 25,
    parameter int DW        = 16
) (
    input  logic                        ram_clk,
    input  logic                        reset,
    input  logic                        rom_load,
    input  logic [NUM_PORTS-1:0]        port_req,
    output logic [NUM_PORTS-1:0]        port_ack,
    input  logic [NUM_PORTS-1:0]        port_we,
    input  logic [NUM_PORTS*AW-1:0]     port_addr,
    input  logic [NUM_PORTS*DW-1:0]     port_din,
    input  logic [NUM_PORTS*DW/8-1:0]   port_be,
    output logic [DW-1:0]               port_dout,
    output logic                        sdr_req,
    output logic                        sdr_we,
    output logic [AW-1:0]               sdr_addr,
    output logic [DW-1:0]               sdr_din,
    output logic [DW/8-1:0]             sdr_be,
    input  logic                        sdr_rdy,
    input  logic [DW-1:0]               sdr_dout,
    output logic                        busy
);

    localparam int BW = DW / 8;
    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        rr_nxt;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_tog;
    logic [IW-1:0]        winner;
    logic [IW-1:0]        cand;
    logic                 found;
    logic                 grant;
    logic                 done;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] eligible;

    // Unpacked views of the packed per-port command fields.
    logic [AW-1:0] addr_arr [NUM_PORTS];
    logic [DW-1:0] din_arr  [NUM_PORTS];
    logic [BW-1:0] be_arr   [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_arr[g] = port_addr[g*AW +: AW];
        assign din_arr[g]  = port_din[g*DW +: DW];
        assign be_arr[g]   = port_be[g*BW +: BW];
    end

    // A port is pending while its request toggle differs from its ack.
    // During a ROM download, only the loader port may compete.
    always_comb begin
        pending  = port_req ^ port_ack;
        eligible = rom_load ? (pending & {{(NUM_PORTS-1){1'b0}}, 1'b1}) : pending;
    end

    // Round-robin scan starting at rr_ptr.  When rom_load is high, only bit 0
    // of eligible can be set, so the same scan always yields port 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        rr_nxt = IW'((int'(winner) + 1) % NUM_PORTS);
    end

    // A completion pulse that coincides with the command strobe is illegal.
    // It is ignored, so only a pulse in a later WAIT cycle ends the transfer.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sdr_rdy && !sdr_req) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            port_ack  <= '0;
            port_dout <= '0;
            sdr_req   <= 1'b0;
            sdr_we    <= 1'b0;
            sdr_addr  <= '0;
            sdr_din   <= '0;
            sdr_be    <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            gnt_tog   <= 1'b0;
        end else begin
            sdr_req <= 1'b0;
            if (grant) begin
                sdr_req  <= 1'b1;
                sdr_we   <= port_we[winner];
                sdr_addr <= addr_arr[winner];
                sdr_din  <= din_arr[winner];
                sdr_be   <= be_arr[winner];
                gnt_idx  <= winner;
                gnt_tog  <= port_req[winner];
                busy     <= 1'b1;
                rr_ptr   <= rr_nxt;
            end
            // The ack is returned as the request value captured at grant.
            // A requester that toggles again mid-transfer therefore stays
            // pending and is served once more.
            if (done) begin
                port_ack[gnt_idx] <= gnt_tog;
                if (!sdr_we) begin
                    port_dout <= sdr_dout;
                end
                busy <= 1'b0;
            end
        end
    end

endmodule
